lives_counter: RTL and testbench
================================

LIVES_COUNTER -- requirements
Module: lives_counter

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 24: game_clk cycles (one second at 24 Hz) during which further deaths are ignored after a decrement.
REQ-002 clk  input  1  game clock; all state changes on its rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 load  input  1  loads lives from load_tens/load_ones and arms the counter.
REQ-005 load_tens  input  4  BCD tens digit of the starting lives.
REQ-006 load_ones  input  4  BCD ones digit of the starting lives.
REQ-007 death  input  1  player-death level; only its rising edge counts.
REQ-008 win  input  1  level-complete pulse; disarms the counter.
REQ-009 tens  output  4  BCD tens digit of remaining lives.
REQ-010 ones  output  4  BCD ones digit of remaining lives.
REQ-011 active  output  1  high while in ACTIVE.
REQ-012 game_over  output  1  high while in GAME_OVER.
REQ-013 dec_pulse  output  1  one-cycle strobe, high in the same cycle as each decremented count.

Function
REQ-014 States SHALL be IDLE, ACTIVE and GAME_OVER; active and game_over SHALL be registered decodes of the state.
REQ-015 death_q SHALL register death every cycle in all states; death_edge = death & ~death_q.
REQ-016 load SHALL clamp any digit greater than 9 to 9, then write tens/ones one cycle later.
REQ-017 After a load, the next state SHALL be GAME_OVER if the clamped value is 00, otherwise ACTIVE; the load SHALL clear the holdoff count.
REQ-018 load SHALL take effect in every state, including mid-holdoff and GAME_OVER.
REQ-019 In ACTIVE with holdoff count 0, a death_edge SHALL decrement the count by 1 and SHALL set dec_pulse for that cycle.
REQ-020 A decrement SHALL load the holdoff count with HOLDOFF_CYCLES.
REQ-021 Decrement arithmetic: ones > 0 gives ones-1; ones == 0 gives ones=9 and tens-1 (borrow).
REQ-022 The counter SHALL never decrement below 00.
REQ-023 A decrement that reaches 00 SHALL move the state to GAME_OVER on the same edge that writes 00.
REQ-024 The holdoff count SHALL decrement by 1 each cycle while nonzero.
REQ-025 death_edge events during holdoff SHALL be dropped, not queued.
REQ-026 win in ACTIVE SHALL move the state to IDLE with tens/ones retained.
REQ-027 win in IDLE or GAME_OVER SHALL have no effect.
REQ-028 IDLE and GAME_OVER SHALL ignore death_edge and SHALL never assert dec_pulse.
REQ-029 Same-cycle priority SHALL be reset > load > win > death_edge; a losing death_edge SHALL be dropped.

Reset
REQ-030 On reset: tens=0, ones=0, state IDLE, active=0, game_over=0, dec_pulse=0, holdoff count=0, death_q=0.
REQ-031 A reset asserted mid-holdoff or mid-decrement SHALL override all other inputs in that cycle.

Structure
REQ-032 Package lives_pkg SHALL hold the state enum (IDLE, ACTIVE, GAME_OVER), the 4-bit bcd_digit_t typedef and the constant BCD_MAX=9.
REQ-033 One sub-module, bcd_digit_down, SHALL implement a single BCD digit with load, decrement-enable, borrow-in and borrow-out; lives_counter SHALL instantiate two of them, chained.
REQ-034 The holdoff width SHALL be $clog2(HOLDOFF_CYCLES+1).

Verification
REQ-035 Reset, then load 03 -> active=1, tens/ones=0/3 next cycle.
REQ-036 Then three death edges spaced 30 cycles apart -> counts 02, 01, 00, three dec_pulses, game_over=1 with the 00 write.
REQ-037 Load 10, single death edge -> 09 (borrow), dec_pulse once.
REQ-038 Load 10, then a second edge 5 cycles after the first with HOLDOFF_CYCLES=24 -> count stays 09.
REQ-039 Load F/C (invalid digits) -> count 99, active=1.
REQ-040 death edge and load 05 in the same cycle -> count 05, no dec_pulse.
REQ-041 death edge and win in the same cycle -> state IDLE, count unchanged.
REQ-042 death held high through reset release -> no decrement; load 00 -> game_over=1 immediately.

Source files
------------

// File: rtl/lives_pkg.sv
// Shared types and constants for the lives counter.
// Holds the FSM state enum, BCD digit type and digit clamp helper.
package lives_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Out-of-range BCD codes saturate to nine.
    function automatic bcd_digit_t clamp_bcd(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD down-counting digit with load and borrow chaining.
// The digit moves only when enabled and a borrow arrives from below.
module bcd_digit_down
    import lives_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output bcd_digit_t digit,
    output logic       borrow_out
);

    // A borrow ripples upward when this digit sits at zero.
    assign borrow_out = borrow_in & (digit == 4'd0);

    // Digit register: reset, load, or step down with wrap to nine.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en && borrow_in) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/lives_counter.sv
// Two-digit BCD lives counter with death-edge holdoff.
// Load arms the counter, deaths decrement it, win parks it in IDLE.
module lives_counter
    import lives_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       death,
    input  logic       win,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       active,
    output logic       game_over,
    output logic       dec_pulse
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES);

    state_t        state;
    state_t        next_state;
    logic [HW-1:0] holdoff;
    logic [HW-1:0] next_holdoff;
    logic          death_q;
    logic          death_edge;
    bcd_digit_t    tens_ld;
    bcd_digit_t    ones_ld;
    logic          ones_borrow;
    logic          at_zero;
    logic          last_life;
    logic          dec;

    assign death_edge = death & ~death_q;
    assign tens_ld    = clamp_bcd(load_tens);
    assign ones_ld    = clamp_bcd(load_ones);
    assign last_life  = (tens == 4'd0) && (ones == 4'd1);

    // Lower-priority events lose to load and win; a zero count never steps.
    assign dec = (state == ACTIVE) && (holdoff == '0) && death_edge &&
                 !load && !win && !at_zero;

    bcd_digit_down u_ones (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (ones_ld),
        .dec_en     (dec),
        .borrow_in  (1'b1),
        .digit      (ones),
        .borrow_out (ones_borrow)
    );

    // The tens borrow-out is high only when the whole count reads 00.
    bcd_digit_down u_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (tens_ld),
        .dec_en     (dec),
        .borrow_in  (ones_borrow),
        .digit      (tens),
        .borrow_out (at_zero)
    );

    // Next state and holdoff with load > win > death priority.
    always_comb begin
        next_state   = state;
        next_holdoff = (holdoff != '0) ? holdoff - HW'(1) : holdoff;
        if (load) begin
            next_holdoff = '0;
            if (tens_ld == 4'd0 && ones_ld == 4'd0) begin
                next_state = GAME_OVER;
            end else begin
                next_state = ACTIVE;
            end
        end else if (state == ACTIVE && win) begin
            next_state = IDLE;
        end else if (dec) begin
            next_holdoff = HOLD_INIT;
            if (last_life) begin
                next_state = GAME_OVER;
            end
        end
    end

    // State register with registered status decodes and strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            holdoff   <= '0;
            death_q   <= 1'b0;
            active    <= 1'b0;
            game_over <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            state     <= next_state;
            holdoff   <= next_holdoff;
            death_q   <= death;
            active    <= (next_state == ACTIVE);
            game_over <= (next_state == GAME_OVER);
            dec_pulse <= dec;
        end
    end

endmodule

// File: tb/tb_lives_counter.sv
// Scoreboard bench for lives_counter.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_lives_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       death = 1'b0;
    logic       win = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       active;
    logic       game_over;
    logic       dec_pulse;

    typedef struct {
        string      name;
        logic [3:0] t;
        logic [3:0] o;
        logic       a;
        logic       g;
        logic       dp;
    } snap_t;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       g;
    } dec_t;

    snap_t snap_q[$];
    dec_t  dec_q[$];
    logic  probe = 1'b0;
    logic  end_chk = 1'b0;
    int    checks = 0;
    int    errors = 0;

    lives_counter #(.HOLDOFF_CYCLES(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .death     (death),
        .win       (win),
        .tens      (tens),
        .ones      (ones),
        .active    (active),
        .game_over (game_over),
        .dec_pulse (dec_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: every decrement strobe and every probe is checked here.
    always @(negedge clk) begin
        if (dec_pulse) begin
            checks++;
            if (dec_q.size() == 0) begin
                errors++;
                $display("FAIL dec_unexpected: got %0d%0d go=%0b, required no dec_pulse",
                         tens, ones, game_over);
            end else begin
                dec_t d;
                d = dec_q.pop_front();
                if (tens !== d.t || ones !== d.o || game_over !== d.g) begin
                    errors++;
                    $display("FAIL dec_value: got %0d%0d go=%0b, required %0d%0d go=%0b",
                             tens, ones, game_over, d.t, d.o, d.g);
                end
            end
        end
        if (probe && snap_q.size() != 0) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            if (tens !== s.t || ones !== s.o || active !== s.a ||
                game_over !== s.g || dec_pulse !== s.dp) begin
                errors++;
                $display("FAIL %s: got %0d%0d a=%0b g=%0b dp=%0b, required %0d%0d a=%0b g=%0b dp=%0b",
                         s.name, tens, ones, active, game_over, dec_pulse,
                         s.t, s.o, s.a, s.g, s.dp);
            end
        end
        if (end_chk) begin
            checks++;
            if (dec_q.size() != 0) begin
                errors++;
                $display("FAIL dec_missing: got %0d pending, required 0",
                         dec_q.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] t,
                         input logic [3:0] o, input logic a,
                         input logic g, input logic dp);
        snap_t s;
        s.name = name;
        s.t = t;
        s.o = o;
        s.a = a;
        s.g = g;
        s.dp = dp;
        snap_q.push_back(s);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic expect_dec(input logic [3:0] t, input logic [3:0] o,
                              input logic g);
        dec_t d;
        d.t = t;
        d.o = o;
        d.g = g;
        dec_q.push_back(d);
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load_tens = t;
        load_ones = o;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic edge_death();
        death = 1'b1;
        cyc(1);
        death = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        reset = 1'b0;
        check("reset", 0, 0, 0, 0, 0);

        do_load(4'd0, 4'd3);
        check("load03", 0, 3, 1, 0, 0);
        expect_dec(0, 2, 0);
        edge_death();
        cyc(29);
        expect_dec(0, 1, 0);
        edge_death();
        cyc(29);
        expect_dec(0, 0, 1);
        edge_death();
        check("gameover", 0, 0, 0, 1, 1);

        do_load(4'd1, 4'd0);
        check("load10", 1, 0, 1, 0, 0);
        expect_dec(0, 9, 0);
        edge_death();
        check("borrow", 0, 9, 1, 0, 1);
        cyc(4);
        edge_death();
        check("holdoff_drop", 0, 9, 1, 0, 0);
        cyc(19);
        expect_dec(0, 8, 0);
        edge_death();
        check("holdoff_end", 0, 8, 1, 0, 1);

        cyc(1);
        do_load(4'hF, 4'hC);
        check("clamp", 9, 9, 1, 0, 0);

        death = 1'b1;
        do_load(4'd0, 4'd5);
        death = 1'b0;
        check("load_prio", 0, 5, 1, 0, 0);
        cyc(1);
        expect_dec(0, 4, 0);
        edge_death();
        cyc(2);
        do_load(4'd0, 4'd7);
        check("reload", 0, 7, 1, 0, 0);
        expect_dec(0, 6, 0);
        edge_death();
        check("reload_dec", 0, 6, 1, 0, 1);

        cyc(1);
        death = 1'b1;
        win = 1'b1;
        cyc(1);
        win = 1'b0;
        death = 1'b0;
        check("win_prio", 0, 6, 0, 0, 0);
        cyc(1);
        edge_death();
        check("idle_death", 0, 6, 0, 0, 0);
        win = 1'b1;
        cyc(1);
        win = 1'b0;
        check("idle_win", 0, 6, 0, 0, 0);

        death = 1'b1;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        check("rst_death", 0, 0, 0, 0, 0);
        do_load(4'd0, 4'd0);
        check("load00", 0, 0, 0, 1, 0);
        win = 1'b1;
        cyc(1);
        win = 1'b0;
        check("over_win", 0, 0, 0, 1, 0);
        death = 1'b0;
        do_load(4'd0, 4'd1);
        check("load01", 0, 1, 1, 0, 0);
        expect_dec(0, 0, 1);
        edge_death();
        check("last_life", 0, 0, 0, 1, 1);
        cyc(1);
        edge_death();
        check("over_death", 0, 0, 0, 1, 0);

        do_load(4'd0, 4'd5);
        expect_dec(0, 4, 0);
        edge_death();
        cyc(2);
        reset = 1'b1;
        load_ones = 4'd9;
        load = 1'b1;
        death = 1'b1;
        cyc(1);
        reset = 1'b0;
        load = 1'b0;
        death = 1'b0;
        check("rst_override", 0, 0, 0, 0, 0);

        cyc(3);
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
